// File: rtl/udm_arb_pkg.sv
// udm_arb_pkg
// Shared definitions for the UDM/CPU bus arbiter: FSM state encoding,
// parameter defaults and the wait-counter width.
package udm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT  = 1024;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam int unsigned CNT_W            = 16;

endpackage

// File: rtl/udm_arb_rr.sv
// udm_arb_rr
// Two-requester round-robin picker. When both masters request, the one
// that was not granted last wins; a single requester always wins.
// Ports:
//   req_i        [1:0]  request vector (bit 0 = UDM, bit 1 = CPU)
//   last_grant_i [1:0]  one-hot owner of the most recently finished transaction
//   grant_o      [1:0]  one-hot winner (all zero when nobody requests)
module udm_arb_rr
    import udm_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i[0] ? 2'b10 : 2'b01;
        end else begin
            // Zero or one request: the vector is already one-hot (or empty).
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/udm_bus_arbiter.sv
// udm_bus_arbiter
// Arbitrates two masters (m0 = UDM, m1 = CPU) onto one shared slave bus.
// IDLE registers a round-robin grant, REQ presents the granted master's
// fields to the slave until s_ack_i, WAIT_RESP waits for the read response.
// A 16-bit wait counter aborts a stalled transaction after TIMEOUT cycles,
// delivering the pending strobe (ERR_DATA for reads) with a timeout_o pulse.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   mN_req_i, mN_we_i              master request / write enable (N = 0, 1)
//   mN_addr_bi, mN_wdata_bi [31:0] master address / write data
//   mN_be_bi [3:0]                 master byte enables
//   mN_ack_o, mN_resp_o            accept strobe / read-response strobe
//   mN_rdata_bo [31:0]             read data, valid with mN_resp_o
//   s_req_o, s_we_o, s_addr_bo, s_wdata_bo, s_be_bo   shared slave request
//   s_ack_i, s_resp_i, s_rdata_bi  slave accept / response / read data
//   grant_bo [1:0]                 one-hot current owner
//   timeout_o                      one-cycle abort pulse
module udm_bus_arbiter
    import udm_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [31:0] m0_wdata_bi,
    input  logic [3:0]  m0_be_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [31:0] m1_wdata_bi,
    input  logic [3:0]  m1_be_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [31:0] s_wdata_bo,
    output logic [3:0]  s_be_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic [1:0]  grant_bo,
    output logic        timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q;
    logic [1:0]       grant_q;
    logic [1:0]       rr_last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]  rr_grant;
    logic        in_req;
    logic        in_wait;
    logic        cnt_expired;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        ack_stb;
    logic        resp_stb;
    logic        abort_req;
    logic        abort_wait;
    logic        done;
    logic        to_wait;
    logic [31:0] rdata_sel;

    udm_arb_rr u_rr (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (rr_last_q),
        .grant_o      (rr_grant)
    );

    always_comb begin
        in_req      = (state_q == ST_REQ);
        in_wait     = (state_q == ST_WAIT_RESP);
        cnt_expired = (cnt_q == CNT_LAST);

        sel_we    = grant_q[1] ? m1_we_i     : m0_we_i;
        sel_addr  = grant_q[1] ? m1_addr_bi  : m0_addr_bi;
        sel_wdata = grant_q[1] ? m1_wdata_bi : m0_wdata_bi;
        sel_be    = grant_q[1] ? m1_be_bi    : m0_be_bi;

        abort_req  = in_req  & ~s_ack_i  & cnt_expired;
        abort_wait = in_wait & ~s_resp_i & cnt_expired;

        ack_stb  = in_req & (s_ack_i | cnt_expired);
        // A read aborted before acceptance also gets its error response so
        // the master is never left waiting; s_resp_i on a write is ignored.
        resp_stb = (in_req & ~sel_we & ((s_ack_i & s_resp_i) | abort_req))
                 | (in_wait & (s_resp_i | cnt_expired));

        rdata_sel = (abort_req | abort_wait) ? ERR_DATA : s_rdata_bi;

        // When s_ack_i is high abort_req is low, so for reads the same-cycle
        // response alone decides between finishing and waiting.
        done    = (in_req & ack_stb & (sel_we | s_resp_i | abort_req))
                | (in_wait & resp_stb);
        to_wait = in_req & s_ack_i & ~sel_we & ~s_resp_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            // "m1 was last" gives m0 the priority after reset.
            rr_last_q <= 2'b10;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req_i | m1_req_i) begin
                        grant_q <= rr_grant;
                        state_q <= ST_REQ;
                        cnt_q   <= '0;
                    end
                end
                ST_REQ, ST_WAIT_RESP: begin
                    if (done) begin
                        state_q   <= ST_IDLE;
                        rr_last_q <= grant_q;
                        grant_q   <= 2'b00;
                        cnt_q     <= '0;
                    end else if (to_wait) begin
                        state_q <= ST_WAIT_RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Slave fields are zero outside REQ so nothing leaks while idle or in reset.
    assign s_req_o    = in_req;
    assign s_we_o     = in_req & sel_we;
    assign s_addr_bo  = in_req ? sel_addr  : 32'h0;
    assign s_wdata_bo = in_req ? sel_wdata : 32'h0;
    assign s_be_bo    = in_req ? sel_be    : 4'h0;

    assign m0_ack_o    = ack_stb  & grant_q[0];
    assign m1_ack_o    = ack_stb  & grant_q[1];
    assign m0_resp_o   = resp_stb & grant_q[0];
    assign m1_resp_o   = resp_stb & grant_q[1];
    assign m0_rdata_bo = (resp_stb & grant_q[0]) ? rdata_sel : 32'h0;
    assign m1_rdata_bo = (resp_stb & grant_q[1]) ? rdata_sel : 32'h0;

    assign grant_bo  = grant_q;
    assign timeout_o = abort_req | abort_wait;

endmodule

// File: tb/tb_udm_bus_arbiter.sv
module tb_udm_bus_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
    logic [3:0]  m0_be_bi, m1_be_bi;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_bi;
    logic [1:0]  grant_bo;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    exp_t ack_q[$];
    exp_t resp_q[$];

    udm_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_bi  (m0_addr_bi),
        .m0_wdata_bi (m0_wdata_bi),
        .m0_be_bi    (m0_be_bi),
        .m0_ack_o    (m0_ack_o),
        .m0_resp_o   (m0_resp_o),
        .m0_rdata_bo (m0_rdata_bo),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_bi  (m1_addr_bi),
        .m1_wdata_bi (m1_wdata_bi),
        .m1_be_bi    (m1_be_bi),
        .m1_ack_o    (m1_ack_o),
        .m1_resp_o   (m1_resp_o),
        .m1_rdata_bo (m1_rdata_bo),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_addr_bo   (s_addr_bo),
        .s_wdata_bo  (s_wdata_bo),
        .s_be_bo     (s_be_bo),
        .s_ack_i     (s_ack_i),
        .s_resp_i    (s_resp_i),
        .s_rdata_bi  (s_rdata_bi),
        .grant_bo    (grant_bo),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe the DUT produces must match the next
    // queued expectation; strobes nobody expected are reported.
    always @(negedge clk_i) begin
        exp_t e;
        if (m0_ack_o | m1_ack_o) begin
            check_val("ack_expected", 32'(ack_q.size() != 0), 1);
            if (ack_q.size() != 0) begin
                e = ack_q.pop_front();
                check_val("ack_master", {m1_ack_o, m0_ack_o}, (e.m == 1) ? 2 : 1);
                check_val("ack_grant", grant_bo, (e.m == 1) ? 2 : 1);
                check_val("ack_tmo", timeout_o, e.tmo);
                $display("ack   m%0d tmo=%0b @%0t", e.m, timeout_o, $time);
            end
        end
        if (m0_resp_o | m1_resp_o) begin
            check_val("resp_expected", 32'(resp_q.size() != 0), 1);
            if (resp_q.size() != 0) begin
                e = resp_q.pop_front();
                check_val("resp_master", {m1_resp_o, m0_resp_o}, (e.m == 1) ? 2 : 1);
                check_val("resp_rdata", (e.m == 1) ? m1_rdata_bo : m0_rdata_bo, e.rdata);
                check_val("resp_other_rdata", (e.m == 1) ? m0_rdata_bo : m1_rdata_bo, 0);
                check_val("resp_tmo", timeout_o, e.tmo);
                $display("resp  m%0d rdata=%h tmo=%0b @%0t", e.m,
                         (e.m == 1) ? m1_rdata_bo : m0_rdata_bo, timeout_o, $time);
            end
        end
        if (timeout_o)
            check_val("tmo_has_strobe", 32'(m0_ack_o | m1_ack_o | m0_resp_o | m1_resp_o), 1);
    end

    task automatic drive_master(input int m, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        if (m == 0) begin
            m0_req_i = 1'b1; m0_we_i = we; m0_addr_bi = addr; m0_wdata_bi = wdata; m0_be_bi = be;
        end else begin
            m1_req_i = 1'b1; m1_we_i = we; m1_addr_bi = addr; m1_wdata_bi = wdata; m1_be_bi = be;
        end
    endtask

    task automatic drop_master(input int m);
        if (m == 0) m0_req_i = 1'b0;
        else        m1_req_i = 1'b0;
    endtask

    // Wait in the current state until timeout_o, returning the cycle index.
    task automatic wait_tmo(output int n);
        for (n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (timeout_o) break;
            @(posedge clk_i); #1;
            s_resp_i = 1'b0;
        end
    endtask

    // ack_dly < 0: never ack (abort in REQ). resp_dly: 0 = with ack,
    // > 0 = cycles after ack, < 0 = never (abort in WAIT_RESP).
    task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int ack_dly, input int resp_dly,
                           input logic [31:0] rd, input bit keep);
        exp_t e;
        int   n;
        drive_master(m, we, addr, wdata, be);
        e.m = m; e.tmo = (ack_dly < 0); e.rdata = 32'h0;
        ack_q.push_back(e);
        if (!we) begin
            e.tmo   = (resp_dly < 0);
            e.rdata = (resp_dly < 0) ? ERR : rd;
            resp_q.push_back(e);
        end
        for (n = 0; n < 20; n++) begin
            @(posedge clk_i); #1;
            if (grant_bo != 2'b00) break;
        end
        $display("txn   m%0d we=%0b addr=%h grant=%b", m, we, addr, grant_bo);
        check_val("grant", grant_bo, (m == 1) ? 2 : 1);
        check_val("s_req", s_req_o, 1);
        check_val("s_we", s_we_o, we);
        check_val("s_addr", s_addr_bo, addr);
        check_val("s_wdata", s_wdata_bo, wdata);
        check_val("s_be", s_be_bo, be);
        if (we) s_resp_i = 1'b1;   // stray response on a write must be ignored
        if (ack_dly < 0) begin
            wait_tmo(n);
            check_val("req_tmo_cycle", n, TMO - 1);
            @(posedge clk_i); #1;
            s_resp_i = 1'b0;
            if (!keep) drop_master(m);
        end else begin
            repeat (ack_dly) begin @(posedge clk_i); #1; s_resp_i = 1'b0; end
            s_ack_i = 1'b1;
            if (!we && resp_dly == 0) begin s_resp_i = 1'b1; s_rdata_bi = rd; end
            @(posedge clk_i); #1;
            s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_bi = 32'h0;
            if (!keep) drop_master(m);
            if (!we && resp_dly != 0) begin
                check_val("wait_s_req", s_req_o, 0);
                if (resp_dly > 0) begin
                    repeat (resp_dly - 1) begin @(posedge clk_i); #1; end
                    s_resp_i = 1'b1; s_rdata_bi = rd;
                    @(posedge clk_i); #1;
                    s_resp_i = 1'b0; s_rdata_bi = 32'h0;
                end else begin
                    wait_tmo(n);
                    check_val("resp_tmo_cycle", n, TMO - 1);
                    @(posedge clk_i); #1;
                    // A late response after the abort must produce nothing.
                    s_resp_i = 1'b1; s_rdata_bi = 32'h12345678;
                    @(posedge clk_i); #1;
                    s_resp_i = 1'b0; s_rdata_bi = 32'h0;
                end
            end
        end
        check_val("idle_grant", grant_bo, 0);
        check_val("idle_s_req", s_req_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst_n_i = 1'b0;
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_wdata_bi = 0; m0_be_bi = 0;
        m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 0; m1_wdata_bi = 0; m1_be_bi = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
        m0_req_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_outs", {grant_bo, s_req_o, timeout_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o}, 0);
        m0_req_i = 0; m1_req_i = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // m0 write, ack two cycles into REQ
        run_txn(0, 1'b1, 32'h80000000, 32'h0102EFD8, 4'hF, 2, 0, 32'h0, 1'b0);
        // m1 read, ack at once, response three cycles later
        run_txn(1, 1'b0, 32'h0000000C, 32'h0, 4'hF, 0, 3, 32'h00000055, 1'b0);
        // read with ack and response in the same cycle
        run_txn(0, 1'b0, 32'h00000010, 32'h0, 4'h3, 1, 0, 32'hA5A50001, 1'b0);
        // write never acked: abort in REQ
        run_txn(1, 1'b1, 32'h00000020, 32'h00000077, 4'h1, -1, 0, 32'h0, 1'b0);

        // both masters keep requesting: grants must alternate m0,m1,m0,m1
        drive_master(1, 1'b1, 32'h00000104, 32'hC0DE0001, 4'hF);
        for (int i = 0; i < 4; i++)
            run_txn(i % 2, 1'b1, 32'h00000100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF,
                    i % 2, 0, 32'h0, (i < 3));
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(posedge clk_i); #1;

        // m0 read with no response: abort in WAIT_RESP, late response ignored
        run_txn(0, 1'b0, 32'h00000030, 32'h0, 4'hF, 0, -1, 32'h0, 1'b0);

        // reset while m1 waits for its response
        drive_master(1, 1'b0, 32'h00000040, 32'h0, 4'hF);
        e.m = 1; e.tmo = 1'b0; e.rdata = 32'h0;
        ack_q.push_back(e);
        for (n = 0; n < 20; n++) begin
            @(posedge clk_i); #1;
            if (grant_bo != 2'b00) break;
        end
        check_val("rst_txn_grant", grant_bo, 2);
        s_ack_i = 1'b1;
        @(posedge clk_i); #1;
        s_ack_i = 1'b0; m1_req_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        $display("reset asserted in WAIT_RESP");
        check_val("midrst_outs", {grant_bo, s_req_o, s_we_o, timeout_o, m0_ack_o, m1_ack_o,
                                  m0_resp_o, m1_resp_o}, 0);
        check_val("midrst_rdata", m1_rdata_bo | m0_rdata_bo | s_addr_bo, 0);
        s_resp_i = 1'b1; s_rdata_bi = 32'h99999999;
        repeat (2) @(posedge clk_i);
        #1;
        s_resp_i = 1'b0; s_rdata_bi = 32'h0;
        rst_n_i = 1'b1;
        // last completion before reset was m0; after reset m0 must win again
        drive_master(1, 1'b1, 32'h00000050, 32'h00005050, 4'hC);
        run_txn(0, 1'b1, 32'h00000060, 32'h00006060, 4'h3, 0, 0, 32'h0, 1'b0);
        run_txn(1, 1'b1, 32'h00000050, 32'h00005050, 4'hC, 0, 0, 32'h0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check_val("ack_q_empty", ack_q.size(), 0);
        check_val("resp_q_empty", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
